// File: rtl/rf_sched_pkg.sv
// Shared types and widths for the register-file writeback scheduler.
package rf_sched_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        DRAIN
    } sched_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector for registers awaiting MDU results, and the decode hazard compare.
module rf_scoreboard
    import rf_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    output logic              hazard
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_addr != '0) set_mask[set_addr] = 1'b1;
        if (clr_en)                   clr_mask[clr_addr] = 1'b1;
    end

    // Clear is applied before set so a same-cycle set on the same register wins.
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end

    always_comb begin
        hazard = ((rs1 != '0) && busy[rs1])
              || ((rs2 != '0) && busy[rs2])
              || ((rd  != '0) && busy[rd]);
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between the pipeline WB stage and the MDU,
// holding one MDU result and forcing a one-cycle pipeline stall to bound MDU starvation.
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wb_en,
    input  logic [REG_AW-1:0] pipe_wb_addr,
    input  logic [XLEN-1:0]   pipe_wb_data,
    input  logic              mdu_valid,
    input  logic [REG_AW-1:0] mdu_addr,
    input  logic [XLEN-1:0]   mdu_data,
    output logic              mdu_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    output logic              hazard,
    output logic              pipe_stall,
    output logic              rf_wb_en,
    output logic [REG_AW-1:0] rf_wb_addr,
    output logic [XLEN-1:0]   rf_wb_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    sched_state_e      state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [REG_AW-1:0] buf_addr;
    logic [XLEN-1:0]   buf_data;
    logic              buf_load;
    logic              pwr;
    logic              mdu_wr;
    logic              wr_en;
    logic              clr_en;
    logic [REG_AW-1:0] clr_addr;

    assign pwr     = pipe_wb_en && (pipe_wb_addr != '0);
    assign mdu_wr  = mdu_valid && (mdu_addr != '0);
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        buf_load   = 1'b0;
        wr_en      = 1'b0;
        rf_wb_addr = pipe_wb_addr;
        rf_wb_data = pipe_wb_data;
        clr_en     = 1'b0;
        clr_addr   = buf_addr;
        case (state)
            IDLE: begin
                if (pwr) begin
                    wr_en = 1'b1;
                    if (mdu_wr) begin
                        buf_load  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = HELD;
                    end
                end else if (mdu_wr) begin
                    wr_en      = 1'b1;
                    rf_wb_addr = mdu_addr;
                    rf_wb_data = mdu_data;
                    clr_en     = 1'b1;
                    clr_addr   = mdu_addr;
                end
            end
            HELD: begin
                if (pwr) begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_W'(STARVE_LIMIT)) state_nxt = DRAIN;
                end else begin
                    wr_en      = 1'b1;
                    rf_wb_addr = buf_addr;
                    rf_wb_data = buf_data;
                    clr_en     = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            DRAIN: begin
                wr_en      = 1'b1;
                rf_wb_addr = buf_addr;
                rf_wb_data = buf_data;
                clr_en     = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: the holding buffer is deliberately not reset; it is only read while state says it is valid.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_addr <= mdu_addr;
            buf_data <= mdu_data;
        end
    end

    assign rf_wb_en   = wr_en && !rst;
    assign mdu_ready  = (state == IDLE);
    assign pipe_stall = (state == DRAIN);

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_valid),
        .set_addr (issue_rd),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .hazard   (hazard)
    );

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Shares the register file's single write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Holds one MDU result when the pipeline owns the port and bounds MDU starvation by stalling the pipeline for one cycle. Keeps a busy scoreboard of registers awaiting MDU results and flags read-after-write and write-after-write hazards to decode. Sits between the WB stage, the MDU, and the register file write port.

## Interface
- STARVE_LIMIT, 4: maximum number of consecutive cycles a held MDU result may be blocked before the pipeline is stalled. Must be ≥1.
- clk  in  1  clock. All flops update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_wb_en  in  1  pipeline writeback request.
- pipe_wb_addr  in  5  pipeline destination register.
- pipe_wb_data  in  32  pipeline result.
- mdu_valid  in  1  MDU result valid.
- mdu_addr  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  MDU result is accepted this cycle.
- issue_valid  in  1  an instruction is dispatched to the MDU this cycle.
- issue_rd  in  5  destination register of the dispatched instruction.
- dec_rs1, dec_rs2, dec_rd  in  5 each  register addresses of the instruction in decode.
- hazard  out  1  decode must stall.
- pipe_stall  out  1  WB stage must hold its contents; pipe_wb_en is ignored this cycle.
- rf_wb_en, rf_wb_addr, rf_wb_data  out  1/5/32  register file write port.

## Operation
- A request is an effective pipe write (pwr) when pipe_wb_en=1 and pipe_wb_addr≠0.
- An MDU result with mdu_addr=0 is accepted and discarded. It produces no write and has no scoreboard effect.
- The FSM has three states: IDLE, HELD, DRAIN. Reset state is IDLE.
- IDLE:
  - mdu_ready=1.
  - pwr → port is granted to the pipe. If mdu_valid=1 in the same cycle, the MDU result is captured into the buffer and the next state is HELD.
  - !pwr and mdu_valid=1 → the MDU result is written directly to the port. State stays IDLE.
- HELD:
  - mdu_ready=0.
  - !pwr → the buffer is written to the port. Next state is IDLE, and the counter is cleared.
  - pwr → port is granted to the pipe and the counter increments. When cnt+1 == STARVE_LIMIT, the next state is DRAIN.
- DRAIN:
  - pipe_stall=1 and mdu_ready=0.
  - The buffer is written to the port and pipe_wb_en is ignored.
  - Next state is IDLE, and the counter is cleared.
- Scoreboard (32-bit busy vector):
  - Bit 0 is never set.
  - A bit is set when issue_valid=1 and issue_rd≠0.
  - A bit is cleared when an MDU result to that register is written to the port (direct, HELD commit, or DRAIN commit).
  - If a set and a clear hit the same register in the same cycle, set wins.
- hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], with each term forced to 0 when its address is 0. This prevents WAW hazards and pipe writes to pending registers.
- rf_wb_en=0 whenever no write is granted, and always while rst=1.

## Timing
- Pipe writes have zero latency: rf_wb_* is a combinational mux of the inputs and the buffer, selected by the registered state.
- mdu_ready and pipe_stall are decoded from registered state only, with no combinational path from inputs.
- hazard is read from the registered busy vector. A register cleared at cycle t stops causing hazard at t+1, so there is no same-cycle bypass.
- Worst-case starvation: the MDU result is captured at t. With pwr held high, cycles t+1..t+STARVE_LIMIT are blocked, and DRAIN commits at t+STARVE_LIMIT+1.
- Reset values: state=IDLE, cnt=0, busy=0, buffer contents don't-care, mdu_ready=1 (after reset releases), pipe_stall=0, hazard=0, rf_wb_en=0.
- Reset mid-operation drops any buffered result and clears busy. The MDU shares rst and is flushed at the same time.

## Structure
- Package rf_sched_pkg:
  - XLEN=32 and REG_AW=5.
  - enum sched_state_e {IDLE, HELD, DRAIN}.
- Counter width is $clog2(STARVE_LIMIT+1).
- One sub-module: rf_scoreboard, containing the busy vector, the set/clear logic and the hazard compare.
- The FSM, buffer and write-port mux live in the top level.

## Test plan
- Reset, then drive mdu_valid=1, addr=5, data=0x1234 with pipe idle → rf_wb_en=1, addr=5, data=0x1234 in the same cycle; busy[5] cleared next cycle.
- In IDLE, drive pipe write (addr=3, data=0xA) and MDU result (addr=7, data=0xB) together → port writes reg 3, state becomes HELD, mdu_ready=0; next idle cycle writes reg 7 = 0xB.
- STARVE_LIMIT=4, buffer captured at cycle t, pwr held high → pipe writes at t+1..t+4, pipe_stall=1 and buffer write at t+5, mdu_ready=1 at t+6.
- issue_valid with issue_rd=9, then decode presents rs2=9 → hazard=1 until the cycle after the MDU writes reg 9. Decode rs1=0 with busy[0] never set → hazard=0.
- pipe_wb_en=1 with addr 0 alongside an MDU result → MDU result written directly, no capture.
- Assert rst while in HELD with busy[12]=1 → next cycle state is IDLE, busy=0, rf_wb_en=0, and the held data is never written.
